// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, control tokens and alignment states.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  // Control tokens as q[9:0]; the suffix is {C1,C0}.
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } tmds_align_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational 10b word classifier/decoder: control token detect plus
// TMDS data byte recovery. Kept standalone so the data-island path can reuse it.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_WORD_W-1:0] word,
  output logic                   is_token,
  output logic [1:0]             ctrl,
  output logic [7:0]             data
);

  logic [7:0] d;

  // Match the four control tokens; anything else is treated as data.
  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (word)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       is_token = 1'b0;
    endcase
  end

  // Undo the optional DC-balance inversion, then the XOR/XNOR chain (q[8] selects XOR).
  assign d    = word[9] ? ~word[7:0] : word[7:0];
  assign data = {(word[8] ? (d[7:1] ^ d[6:0]) : ~(d[7:1] ^ d[6:0])), d[0]};

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: word-boundary alignment via bitslip requests,
// then pixel/control decode. Fixed two-clock latency from i_word to outputs.
//
// state  | meaning
// SEARCH | hunting for LOCK_COUNT consecutive tokens; slip when window runs out
// SLIP   | one-cycle bitslip pulse followed by SLIP_WAIT settle cycles
// LOCKED | aligned; token runs refresh the window, expiry drops back to SEARCH
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 4
) (
  input  logic                   i_clk_pxl,
  input  logic                   i_reset_n,
  input  logic [TMDS_WORD_W-1:0] i_word,
  output logic                   o_bitslip,
  output logic                   o_locked,
  output logic                   o_de,
  output logic [7:0]             o_data,
  output logic [1:0]             o_ctrl
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SLIP_W-1:0] SLIP_LOAD = SLIP_W'(SLIP_WAIT);

  logic [TMDS_WORD_W-1:0] word_q;
  tmds_align_state_t      state;
  logic [RUN_W-1:0]       run_cnt;
  logic [RUN_W-1:0]       run_nxt;
  logic [WIN_W-1:0]       win_cnt;
  logic [SLIP_W-1:0]      slip_cnt;
  logic                   tok;
  logic [1:0]             tok_ctrl;
  logic [7:0]             dec_data;
  logic                   run_hit;
  logic                   win_expire;
  logic                   locked_nxt;

  tmds_word_decode u_word_decode (
    .word     (word_q),
    .is_token (tok),
    .ctrl     (tok_ctrl),
    .data     (dec_data)
  );

  // Stage 1: capture the deserializer word.
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) word_q <= '0;
    else            word_q <= i_word;
  end

  // Token run tracking; the run is forced to zero while slipping.
  always_comb begin
    run_hit = 1'b0;
    run_nxt = '0;
    if ((state != SLIP) && tok) begin
      run_hit = (run_cnt == RUN_LAST);
      run_nxt = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 1'b1;
    end
  end

  assign win_expire = (win_cnt == WIN_LAST);
  // A run hit beats window expiry in both SEARCH and LOCKED.
  assign locked_nxt = ((state == SEARCH) && run_hit) ||
                      ((state == LOCKED) && (run_hit || !win_expire));

  // Alignment FSM, counters and registered outputs.
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      win_cnt   <= '0;
      slip_cnt  <= '0;
      o_bitslip <= 1'b0;
      o_locked  <= 1'b0;
      o_de      <= 1'b0;
      o_data    <= '0;
      o_ctrl    <= '0;
    end else begin
      run_cnt   <= run_nxt;
      o_bitslip <= 1'b0;
      case (state)
        SEARCH: begin
          if (run_hit) begin
            state   <= LOCKED;
            win_cnt <= '0;
          end else if (win_expire) begin
            state     <= SLIP;
            win_cnt   <= '0;
            slip_cnt  <= SLIP_LOAD;
            o_bitslip <= 1'b1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        SLIP: begin
          if (slip_cnt == '0) begin
            state   <= SEARCH;
            win_cnt <= '0;
          end else begin
            slip_cnt <= slip_cnt - 1'b1;
            win_cnt  <= win_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (run_hit) begin
            win_cnt <= '0;
          end else if (win_expire) begin
            state   <= SEARCH;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: begin
          state   <= SEARCH;
          win_cnt <= '0;
        end
      endcase
      o_locked <= locked_nxt;
      o_de     <= locked_nxt && !tok;
      o_data   <= (locked_nxt && !tok) ? dec_data : 8'h00;
      if (locked_nxt && tok) o_ctrl <= tok_ctrl;
    end
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive side of one TMDS lane for the 480p HDMI/DVI path; the counterpart of the transmit-side TMDS encoder.
- Takes one 10-bit parallel word per pixel clock from an external deserializer (e.g. ISERDES cascade).
- Aligns the word boundary by requesting bitslips until control-token runs are seen, then decodes 8-bit pixel data, 2-bit control (C1,C0) and data enable.
- Three instances (blue/green/red) feed a future sync regenerator; the blue lane's C0/C1 carry hsync/vsync.

Parameters:
- LOCK_COUNT, 8, consecutive control tokens needed to declare/refresh alignment
- SEARCH_WINDOW, 1024, cycles without a qualifying token run before slip (search) or lock loss (locked); must exceed the 800-clock line
- SLIP_WAIT, 4, settle cycles after a bitslip pulse before searching resumes

Ports:
- i_clk_pxl  in  1  pixel clock (25 MHz at 480p)
- i_reset_n  in  1  asynchronous active-low reset
- i_word  in  10  deserialized TMDS word, q[9:0], q[0] first on the wire
- o_bitslip  out  1  one-cycle request to the deserializer to shift the boundary by one bit
- o_locked  out  1  lane aligned
- o_de  out  1  data enable (video period)
- o_data  out  8  decoded pixel byte
- o_ctrl  out  2  {C1,C0} from the last control token

Behaviour:
- Reset (async assert, sync release): all outputs 0; state SEARCH; all counters 0.
- Pipeline: i_word registered at edge t (stage 1); classify/decode from stage 1; outputs and FSM registered at edge t+1. Latency is 2 clocks, fixed in all states.
- Control tokens: 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11 (shown as q[9:0], result {C1,C0}).
- Data decode: d = q[9] ? ~q[7:0] : q[7:0]; o[0]=d[0]; for i=1..7, o[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Run counter: +1 on a control token, saturates at LOCK_COUNT, cleared on a non-token. "Run hit" = the cycle it reaches LOCK_COUNT.
- Window counter: +1 per cycle; cleared on run hit and on every state change.
- FSM SEARCH:
  - Run hit → LOCKED.
  - Window reaches SEARCH_WINDOW-1 with no hit → SLIP.
  - Run hit and window expiry in the same cycle → lock wins.
- FSM SLIP:
  - Lasts 1+SLIP_WAIT cycles; o_bitslip=1 only in the first.
  - Run counter held at 0 throughout; then → SEARCH.
  - Steady misalignment gives pulse spacing of SEARCH_WINDOW+1+SLIP_WAIT (1029) cycles.
- FSM LOCKED:
  - Run hit clears the window.
  - Window expiry → SEARCH; o_locked falls the same edge.
- Output rules:
  - o_locked=1 exactly in LOCKED; it rises on the edge that outputs the LOCK_COUNT-th token.
  - o_de = LOCKED && stage-1 word is not a token.
  - o_data = decoded byte when o_de=1, else 0.
  - o_ctrl updates on every token while LOCKED and holds during data.
  - While not LOCKED, o_de=0, o_data=0 and o_ctrl holds its value.
- Reset mid-operation (including during SLIP): outputs drop to 0 immediately; no residual bitslip.

Decomposition:
- Package tmds_pkg: TMDS_WORD_W=10; the four CTRL_TOKEN constants; typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} tmds_align_state_t.
- Sub-module tmds_word_decode: purely combinational 10b→{is_token, ctrl[1:0], data[7:0]}, reused later by the TERC4/data-island decoder.

Test Plan:
- Reset: i_reset_n=0 with random i_word for 20 cycles → all outputs 0; release → o_bitslip stays 0 for the first 1023 cycles.
- Aligned lock: 8×1101010100 then 0100000000 → o_locked rises with the 8th token's output, o_ctrl=00; next cycle o_de=1, o_data=0x00.
- Decode: after lock, 1011111111 → o_data=0xFE, o_de=1; then 0010101011 → o_de=0, o_ctrl=01, o_data=0.
- Misaligned: stream rotated 3 bits, bench model rotates back one bit per pulse → o_bitslip pulses at 1029-cycle spacing; lock after the 3rd pulse plus 8 tokens.
- Lock loss: after lock, 1024 data words with no token → o_locked falls at expiry, o_de=0; first 1029 later is o_bitslip.
- Reset in SLIP: deassert i_reset_n in the bitslip cycle → o_bitslip drops asynchronously; after release, SEARCH restarts with a full window.
